vga_timing_gen: RTL and testbench

//  Parametrised raster timing generator; next generation of the VGA sync driver.

---
 rtl/vga_timing_gen.sv | 159 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel coordinates, blank/video flags, polarity-configurable
// syncs, line/frame strobes and a frame counter, all advancing on a pixel clock-enable.
module vga_timing_gen #(
  parameter int unsigned H_DISP  = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_PULSE = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_PULSE = 2,
  parameter int unsigned V_BP    = 33,
  parameter int unsigned CW      = 10,
  parameter int unsigned H_POL   = 0,
  parameter int unsigned V_POL   = 0,
  parameter int unsigned FCW     = 8
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  input  logic           i_ce,
  input  logic           i_en,
  output logic [CW-1:0]  o_x_counter,
  output logic [CW-1:0]  o_y_counter,
  output logic           o_video,
  output logic           o_hblank,
  output logic           o_vblank,
  output logic           o_hsync,
  output logic           o_vsync,
  output logic           o_sol,
  output logic           o_sof,
  output logic [FCW-1:0] o_frame_cnt
);

  localparam int unsigned H_END = H_DISP + H_FP + H_PULSE + H_BP;
  localparam int unsigned V_END = V_DISP + V_FP + V_PULSE + V_BP;

  if (H_END > (32'd1 << CW) || V_END > (32'd1 << CW)) begin : g_bad_width
    $error("vga_timing_gen: H_END or V_END exceeds 2**CW");
  end
  if (H_DISP == 0 || H_PULSE == 0 || V_DISP == 0 || V_PULSE == 0) begin : g_bad_zero
    $error("vga_timing_gen: display and pulse parameters must be non-zero");
  end

  // Boundaries held one bit wider than the counters so H_END == 2**CW still compares correctly.
  localparam logic [CW:0]   H_DISP_W = (CW+1)'(H_DISP);
  localparam logic [CW:0]   H_SYN_S  = (CW+1)'(H_DISP + H_FP);
  localparam logic [CW:0]   H_SYN_E  = (CW+1)'(H_DISP + H_FP + H_PULSE);
  localparam logic [CW:0]   V_DISP_W = (CW+1)'(V_DISP);
  localparam logic [CW:0]   V_SYN_S  = (CW+1)'(V_DISP + V_FP);
  localparam logic [CW:0]   V_SYN_E  = (CW+1)'(V_DISP + V_FP + V_PULSE);
  localparam logic [CW-1:0] H_LAST   = CW'(H_END - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_END - 1);
  localparam logic          HS_ON    = (H_POL != 0);
  localparam logic          VS_ON    = (V_POL != 0);

  typedef struct packed {
    logic video;
    logic hblank;
    logic vblank;
    logic hsync;
    logic vsync;
  } flags_t;

  localparam flags_t FLAGS_PARK = '{video: 1'b0, hblank: 1'b1, vblank: 1'b1,
                                    hsync: ~HS_ON, vsync: ~VS_ON};

  function automatic flags_t decode(input logic [CW-1:0] hc, input logic [CW-1:0] vc);
    flags_t    f;
    logic [CW:0] h;
    logic [CW:0] v;
    h        = {1'b0, hc};
    v        = {1'b0, vc};
    f.video  = (h < H_DISP_W) && (v < V_DISP_W);
    f.hblank = (h >= H_DISP_W);
    f.vblank = (v >= V_DISP_W);
    f.hsync  = ((h >= H_SYN_S) && (h < H_SYN_E)) ? HS_ON : ~HS_ON;
    f.vsync  = ((v >= V_SYN_S) && (v < V_SYN_E)) ? VS_ON : ~VS_ON;
    return f;
  endfunction

  logic [CW-1:0]  hc_q, hc_d, hc_n;
  logic [CW-1:0]  vc_q, vc_d, vc_n;
  flags_t         flags_q, flags_d;
  logic           sol_q, sol_d;
  logic           sof_q, sof_d;
  logic [FCW-1:0] frame_q, frame_d;

  // Raster position one pixel ahead of the current one.
  always_comb begin
    hc_n = hc_q;
    vc_n = vc_q;
    if (hc_q == H_LAST) begin
      hc_n = '0;
      vc_n = (vc_q == V_LAST) ? '0 : vc_q + CW'(1);
    end else begin
      hc_n = hc_q + CW'(1);
      vc_n = vc_q;
    end
  end

  // Next state: park dominates, then advance on ce; flags decode the position being moved to.
  always_comb begin
    hc_d    = hc_q;
    vc_d    = vc_q;
    flags_d = flags_q;
    sol_d   = 1'b0;
    sof_d   = 1'b0;
    frame_d = frame_q;
    if (!i_en) begin
      hc_d    = H_LAST;
      vc_d    = V_LAST;
      flags_d = FLAGS_PARK;
    end else if (i_ce) begin
      hc_d    = hc_n;
      vc_d    = vc_n;
      flags_d = decode(hc_n, vc_n);
      sol_d   = (hc_n == '0);
      sof_d   = (hc_n == '0) && (vc_n == '0);
      if (sof_d) begin
        frame_d = frame_q + FCW'(1);
      end else begin
        frame_d = frame_q;
      end
    end else begin
      hc_d    = hc_q;
      vc_d    = vc_q;
    end
  end

  // State registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      hc_q    <= H_LAST;
      vc_q    <= V_LAST;
      flags_q <= FLAGS_PARK;
      sol_q   <= 1'b0;
      sof_q   <= 1'b0;
      frame_q <= '0;
    end else begin
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      flags_q <= flags_d;
      sol_q   <= sol_d;
      sof_q   <= sof_d;
      frame_q <= frame_d;
    end
  end

  assign o_x_counter = hc_q;
  assign o_y_counter = vc_q;
  assign o_video     = flags_q.video;
  assign o_hblank    = flags_q.hblank;
  assign o_vblank    = flags_q.vblank;
  assign o_hsync     = flags_q.hsync;
  assign o_vsync     = flags_q.vsync;
  assign o_sol       = sol_q;
  assign o_sof       = sof_q;
  assign o_frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomised bench for vga_timing_gen: three differently parameterised instances share one
// stimulus stream and are checked every cycle against a linear-pixel-index reference model.
module tb_vga_timing_gen;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rstn;
  logic ce;
  logic en;

  always #5 clk = ~clk;

  // Instance 0: default 800x525; 1: 7x5 active-high; 2: 32x19 with CW exactly fitting H_END.
  int HD [N] = '{640, 4, 20};
  int HF [N] = '{16, 1, 3};
  int HP [N] = '{96, 1, 5};
  int HB [N] = '{48, 1, 4};
  int VD [N] = '{480, 2, 12};
  int VF [N] = '{10, 1, 2};
  int VP [N] = '{2, 1, 2};
  int VB [N] = '{33, 1, 3};
  int HPOL [N] = '{0, 1, 0};
  int VPOL [N] = '{0, 1, 1};
  int FW [N] = '{8, 2, 3};

  logic [9:0] x0, y0, x1, y1;
  logic [4:0] x2, y2;
  logic [7:0] f0;
  logic [1:0] f1;
  logic [2:0] f2;
  logic [N-1:0] vid, hbl, vbl, hs, vs, sol, sof;

  vga_timing_gen u0 (
    .i_clk(clk), .i_rstn(rstn), .i_ce(ce), .i_en(en),
    .o_x_counter(x0), .o_y_counter(y0), .o_video(vid[0]), .o_hblank(hbl[0]),
    .o_vblank(vbl[0]), .o_hsync(hs[0]), .o_vsync(vs[0]), .o_sol(sol[0]),
    .o_sof(sof[0]), .o_frame_cnt(f0)
  );

  vga_timing_gen #(
    .H_DISP(4), .H_FP(1), .H_PULSE(1), .H_BP(1),
    .V_DISP(2), .V_FP(1), .V_PULSE(1), .V_BP(1),
    .CW(10), .H_POL(1), .V_POL(1), .FCW(2)
  ) u1 (
    .i_clk(clk), .i_rstn(rstn), .i_ce(ce), .i_en(en),
    .o_x_counter(x1), .o_y_counter(y1), .o_video(vid[1]), .o_hblank(hbl[1]),
    .o_vblank(vbl[1]), .o_hsync(hs[1]), .o_vsync(vs[1]), .o_sol(sol[1]),
    .o_sof(sof[1]), .o_frame_cnt(f1)
  );

  vga_timing_gen #(
    .H_DISP(20), .H_FP(3), .H_PULSE(5), .H_BP(4),
    .V_DISP(12), .V_FP(2), .V_PULSE(2), .V_BP(3),
    .CW(5), .H_POL(0), .V_POL(1), .FCW(3)
  ) u2 (
    .i_clk(clk), .i_rstn(rstn), .i_ce(ce), .i_en(en),
    .o_x_counter(x2), .o_y_counter(y2), .o_video(vid[2]), .o_hblank(hbl[2]),
    .o_vblank(vbl[2]), .o_hsync(hs[2]), .o_vsync(vs[2]), .o_sol(sol[2]),
    .o_sof(sof[2]), .o_frame_cnt(f2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  // Model state: pos = linear pixel index within the frame, -1 = parked pre-frame position.
  int pos [N];
  int frm [N];
  bit msol [N];
  bit msof [N];

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      pos[d] = -1; frm[d] = 0; msol[d] = 1'b0; msof[d] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int d = 0; d < N; d++) begin
      int he;
      int tot;
      he  = HD[d] + HF[d] + HP[d] + HB[d];
      tot = he * (VD[d] + VF[d] + VP[d] + VB[d]);
      if (!en) begin
        pos[d] = -1; msol[d] = 1'b0; msof[d] = 1'b0;
      end else if (ce) begin
        pos[d]  = (pos[d] + 1) % tot;
        msol[d] = ((pos[d] % he) == 0);
        msof[d] = (pos[d] == 0);
        if (msof[d]) frm[d] = (frm[d] + 1) % (1 << FW[d]);
      end else begin
        msol[d] = 1'b0; msof[d] = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < N; d++) begin
      int he, ve, ex, ey;
      bit ev, ehb, evb, ehs, evs;
      logic [31:0] gx, gy, gf;
      he = HD[d] + HF[d] + HP[d] + HB[d];
      ve = VD[d] + VF[d] + VP[d] + VB[d];
      if (pos[d] < 0) begin
        ex = he - 1; ey = ve - 1;
        ev = 1'b0; ehb = 1'b1; evb = 1'b1;
        ehs = !HPOL[d][0]; evs = !VPOL[d][0];
      end else begin
        ex  = pos[d] % he;
        ey  = pos[d] / he;
        ev  = (ex < HD[d]) && (ey < VD[d]);
        ehb = (ex >= HD[d]);
        evb = (ey >= VD[d]);
        ehs = (ex >= HD[d] + HF[d] && ex < HD[d] + HF[d] + HP[d]) ? HPOL[d][0] : !HPOL[d][0];
        evs = (ey >= VD[d] + VF[d] && ey < VD[d] + VF[d] + VP[d]) ? VPOL[d][0] : !VPOL[d][0];
      end
      case (d)
        0:       begin gx = 32'(x0); gy = 32'(y0); gf = 32'(f0); end
        1:       begin gx = 32'(x1); gy = 32'(y1); gf = 32'(f1); end
        default: begin gx = 32'(x2); gy = 32'(y2); gf = 32'(f2); end
      endcase
      check_eq($sformatf("u%0d.x", d), gx, 32'(ex));
      check_eq($sformatf("u%0d.y", d), gy, 32'(ey));
      check_eq($sformatf("u%0d.video", d), 32'(vid[d]), 32'(ev));
      check_eq($sformatf("u%0d.hblank", d), 32'(hbl[d]), 32'(ehb));
      check_eq($sformatf("u%0d.vblank", d), 32'(vbl[d]), 32'(evb));
      check_eq($sformatf("u%0d.hsync", d), 32'(hs[d]), 32'(ehs));
      check_eq($sformatf("u%0d.vsync", d), 32'(vs[d]), 32'(evs));
      check_eq($sformatf("u%0d.sol", d), 32'(sol[d]), 32'(msol[d]));
      check_eq($sformatf("u%0d.sof", d), 32'(sof[d]), 32'(msof[d]));
      check_eq($sformatf("u%0d.frame", d), gf, 32'(frm[d]));
    end
  endtask

  // Called at a negedge: drive inputs, predict the coming posedge, compare at the next negedge.
  task automatic run_cycle(input bit e, input bit c);
    en = e;
    ce = c;
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic async_reset_midcycle();
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    rstn = 1'b1;
  endtask

  initial begin
    int park_left;
    rstn = 1'b0;
    ce   = 1'b0;
    en   = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    compare_all();
    rstn = 1'b1;

    // Free-running raster.
    for (int i = 0; i < 2500; i++) run_cycle(1'b1, 1'b1);

    // ce alternating 1/0: periods double, strobes stay one clock wide.
    for (int i = 0; i < 1600; i++) run_cycle(1'b1, i[0] == 1'b0);

    // Random ce with occasional park bursts.
    park_left = 0;
    for (int i = 0; i < 20000; i++) begin
      if (park_left > 0) begin
        park_left--;
        run_cycle(1'b0, $urandom_range(0, 1) == 1);
      end else if ($urandom_range(0, 149) == 0) begin
        park_left = $urandom_range(0, 5);
        run_cycle(1'b0, $urandom_range(0, 1) == 1);
      end else begin
        run_cycle(1'b1, $urandom_range(0, 3) != 0);
      end
    end

    // Asynchronous reset mid-frame, then restart as from power-up.
    async_reset_midcycle();
    for (int i = 0; i < 1000; i++) run_cycle(1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
